tilelink_ad_arbiter: RTL
========================

# tilelink_ad_arbiter

Two-master TileLink-UL arbiter covering the A and D channels. It shares one downstream TL-UL slave port, such as the A-D dummy slave on the Rocket tile master port, between two upstream requesters. It allows one transaction in flight at a time, chooses masters by round-robin, locks the grant from A-channel acceptance through the last D beat, and routes every D beat back to the owning master. It sits between the formal wrapper's requesters and the single memory-side slave.

## Interface
Parameters:
- `BEAT_BYTES`, default 4: data bytes per beat. The block is built for 32-bit data only.
- `MAX_SIZE`, default 6: largest legal `a_bits_size`, as log2 bytes. It sets the beat-counter width to `MAX_SIZE-1` bits.

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low. `reset==0` resets.
- `m0_a_valid` in 1; `m0_a_ready` out 1; `m0_a_bits_{opcode[3],param[3],size[4],source[1],address[32],mask[4],data[32]}` in: master 0 A channel.
- `m0_d_ready` in 1; `m0_d_valid` out 1; `m0_d_bits_{opcode[3],param[2],size[4],source[1],sink[1],addr_lo[2],data[32],error[1]}` out: master 0 D channel.
- `m1_*`: same set and directions as `m0_*`, for master 1.
- `s_a_valid` out 1; `s_a_ready` in 1; `s_a_bits_*` out, same fields as the master A channels: downstream A channel.
- `s_d_valid` in 1; `s_d_ready` out 1; `s_d_bits_*` in, same fields as the master D channels: downstream D channel.
- `owner` out 1: current or last grant index, for debug and formal use.
- `busy` out 1: high in every state other than IDLE.

## Operation
- States:
  - **IDLE**: no grant.
  - **ARB**: grant registered, not yet driven.
  - **REQ**: the granted A channel is forwarded.
  - **RESP**: D beats are being forwarded.
- **IDLE**:
  - If exactly one `mX_a_valid` is high, `owner<=X`.
  - If both are high, `owner<=prio`.
  - Move to ARB if any valid is high; otherwise stay.
- **ARB**: unconditional move to REQ. This cycle gives the mux a registered select, so no combinational grant flips.
- **REQ**:
  - Drive `s_a_valid=m[owner]_a_valid` and `s_a_bits=m[owner]_a_bits`.
  - Drive `m[owner]_a_ready=s_a_ready`; the other master's `a_ready` is 0.
  - On `s_a_valid&&s_a_ready`:
    - Latch `op_opcode` and `op_size`.
    - `beat_cnt<=0`.
    - `prio<=~owner`.
    - Move to RESP.
  - If the owner drops valid before acceptance, which is a protocol violation, return to IDLE.
- **RESP**:
  - Drive `m[owner]_d_valid=s_d_valid`, `m[owner]_d_bits=s_d_bits` and `s_d_ready=m[owner]_d_ready`.
  - The other master's `d_valid` is 0.
- **Beat count**: `beats = (op_opcode==Get(4) && op_size>2) ? 1<<(op_size-2) : 1`.
  - Put, Arithmetic, Logical and Intent responses are single-beat.
- **Last beat**: `last = (beat_cnt+1 == beats)`.
  - On a D handshake with `!last`, `beat_cnt<=beat_cnt+1`.
  - On a D handshake with `last`, move to IDLE. `prio` keeps its value from REQ.
- **Illegal size**: `op_size>MAX_SIZE` is treated as `MAX_SIZE`, which is 16 beats.
- **D error**: a D beat with `error=1` is forwarded unchanged and does not shorten the burst.
- **Outputs outside their state**: all `*_bits` outputs are driven to 0 when the path is not selected.

## Timing
- **Reset values**, while `reset==0` and on the cycle it is released:
  - State IDLE.
  - `owner=0`, `prio=0`, `busy=0`.
  - `s_a_valid=0`, `s_d_ready=0`.
  - `m0/m1_a_ready=0`, `m0/m1_d_valid=0`.
  - All bits outputs 0.
- **Arbitration latency**: valid seen in IDLE in cycle N → ARB in N+1 → `s_a_valid` in N+2. The earliest A handshake is N+2.
- **Path mux**: combinational from the registered `owner` and state only. There are no combinational paths from one master's inputs into the other master's outputs.
- **Turnaround**: the last D handshake in cycle M puts the block in IDLE at M+1. A new request is accepted into ARB at M+2 at the earliest.
- **Back-pressure**: `m[owner]_d_ready=0` stalls `s_d_ready`. `beat_cnt` holds.
- **Mid-operation reset**: asynchronous assertion returns the block to IDLE immediately. In-flight beats are dropped and all valids and readys go low in the same cycle.

## Test plan
- **Single master**: m0 issues Get `size=2` at 0x100 → `s_a_valid` 2 cycles later with identical bits. One D beat with `data=0xDEADBEEF` reaches only `m0_d`. `busy` falls 1 cycle after the D handshake.
- **Simultaneous requests after reset**: m0 and m1 both valid → m0 is served first. m1 is granted in the next IDLE→ARB. Then a simultaneous pair → m0 again, confirming strict alternation.
- **Burst**: m1 issues Get `size=4` → exactly 4 D beats route to m1. The FSM enters IDLE only after the 4th beat. m0 `a_ready` stays 0 throughout.
- **Back-pressure**: hold `m0_d_ready=0` for 3 cycles mid-burst → `s_d_ready=0` for those cycles, `beat_cnt` is unchanged, and the beat count is still correct.
- **Single-beat write**: PutFullData (opcode 0) with `size=3` → one AccessAck ends the transaction, with no 2-beat wait.
- **Reset mid-burst**: assert `reset=0` during beat 2 of 4 → all valids and readys are 0 immediately, and `owner=0` and `prio=0` after release.

Source files
------------

// File: rtl/tilelink_ad_arbiter.sv
// Two-master TileLink-UL arbiter for the A and D channels.
// One transaction is in flight at a time. Masters are picked round-robin.
// The grant stays locked from A acceptance until the last D beat.
module tilelink_ad_arbiter #(
  parameter int BEAT_BYTES = 4,
  parameter int MAX_SIZE   = 6
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_bits_opcode,
  input  logic [2:0]  m0_a_bits_param,
  input  logic [3:0]  m0_a_bits_size,
  input  logic        m0_a_bits_source,
  input  logic [31:0] m0_a_bits_address,
  input  logic [3:0]  m0_a_bits_mask,
  input  logic [31:0] m0_a_bits_data,
  input  logic        m0_d_ready,
  output logic        m0_d_valid,
  output logic [2:0]  m0_d_bits_opcode,
  output logic [1:0]  m0_d_bits_param,
  output logic [3:0]  m0_d_bits_size,
  output logic        m0_d_bits_source,
  output logic        m0_d_bits_sink,
  output logic [1:0]  m0_d_bits_addr_lo,
  output logic [31:0] m0_d_bits_data,
  output logic        m0_d_bits_error,

  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_bits_opcode,
  input  logic [2:0]  m1_a_bits_param,
  input  logic [3:0]  m1_a_bits_size,
  input  logic        m1_a_bits_source,
  input  logic [31:0] m1_a_bits_address,
  input  logic [3:0]  m1_a_bits_mask,
  input  logic [31:0] m1_a_bits_data,
  input  logic        m1_d_ready,
  output logic        m1_d_valid,
  output logic [2:0]  m1_d_bits_opcode,
  output logic [1:0]  m1_d_bits_param,
  output logic [3:0]  m1_d_bits_size,
  output logic        m1_d_bits_source,
  output logic        m1_d_bits_sink,
  output logic [1:0]  m1_d_bits_addr_lo,
  output logic [31:0] m1_d_bits_data,
  output logic        m1_d_bits_error,

  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_bits_opcode,
  output logic [2:0]  s_a_bits_param,
  output logic [3:0]  s_a_bits_size,
  output logic        s_a_bits_source,
  output logic [31:0] s_a_bits_address,
  output logic [3:0]  s_a_bits_mask,
  output logic [31:0] s_a_bits_data,

  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_bits_opcode,
  input  logic [1:0]  s_d_bits_param,
  input  logic [3:0]  s_d_bits_size,
  input  logic        s_d_bits_source,
  input  logic        s_d_bits_sink,
  input  logic [1:0]  s_d_bits_addr_lo,
  input  logic [31:0] s_d_bits_data,
  input  logic        s_d_bits_error,

  output logic        owner,
  output logic        busy
);

  localparam int       CNT_W      = MAX_SIZE - 1;
  localparam int       BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [2:0] OP_GET   = 3'd4;

  typedef enum logic [1:0] {IDLE, ARB, REQ, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic               prio;
  logic [2:0]         op_opcode;
  logic [3:0]         op_size;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   beats;
  logic [3:0]         eff_size;
  logic               last;

  logic               a_valid_sel;
  logic [2:0]         a_opcode_sel;
  logic [3:0]         a_size_sel;
  logic               d_ready_sel;
  logic               a_fire;
  logic               d_fire;

  assign a_valid_sel  = owner ? m1_a_valid       : m0_a_valid;
  assign a_opcode_sel = owner ? m1_a_bits_opcode : m0_a_bits_opcode;
  assign a_size_sel   = owner ? m1_a_bits_size   : m0_a_bits_size;
  assign d_ready_sel  = owner ? m1_d_ready       : m0_d_ready;
  assign a_fire       = (state == REQ)  && a_valid_sel && s_a_ready;
  assign d_fire       = (state == RESP) && s_d_valid && d_ready_sel;
  assign busy         = (state != IDLE);

  // Burst length of the latched op: only Get returns multiple beats; oversize clamps to MAX_SIZE
  always_comb begin
    eff_size = (op_size > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : op_size;
    beats    = CNT_W'(1);
    if (op_opcode == OP_GET && eff_size > 4'(BEAT_SHIFT))
      beats = CNT_W'(1) << (eff_size - 4'(BEAT_SHIFT));
  end

  assign last = ((beat_cnt + CNT_W'(1)) == beats);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; ARB exists so the path mux only ever sees a registered owner
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (m0_a_valid || m1_a_valid) state_next = ARB;
      ARB:  state_next = REQ;
      REQ: begin
        if (a_fire)            state_next = RESP;
        else if (!a_valid_sel) state_next = IDLE;
      end
      RESP: if (d_fire && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, round-robin priority, latched op and beat counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b0;
      prio      <= 1'b0;
      op_opcode <= '0;
      op_size   <= '0;
      beat_cnt  <= '0;
    end else begin
      if (state == IDLE) begin
        if (m0_a_valid && m1_a_valid) owner <= prio;
        else if (m1_a_valid)          owner <= 1'b1;
        else if (m0_a_valid)          owner <= 1'b0;
      end
      if (a_fire) begin
        op_opcode <= a_opcode_sel;
        op_size   <= a_size_sel;
        beat_cnt  <= '0;
        prio      <= ~owner;
      end else if (d_fire && !last) begin
        beat_cnt  <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Path muxes driven from registered owner and state; unselected paths read as zero
  always_comb begin
    s_a_valid         = 1'b0;
    s_a_bits_opcode   = '0;
    s_a_bits_param    = '0;
    s_a_bits_size     = '0;
    s_a_bits_source   = 1'b0;
    s_a_bits_address  = '0;
    s_a_bits_mask     = '0;
    s_a_bits_data     = '0;
    m0_a_ready        = 1'b0;
    m1_a_ready        = 1'b0;
    s_d_ready         = 1'b0;
    m0_d_valid        = 1'b0;
    m0_d_bits_opcode  = '0;
    m0_d_bits_param   = '0;
    m0_d_bits_size    = '0;
    m0_d_bits_source  = 1'b0;
    m0_d_bits_sink    = 1'b0;
    m0_d_bits_addr_lo = '0;
    m0_d_bits_data    = '0;
    m0_d_bits_error   = 1'b0;
    m1_d_valid        = 1'b0;
    m1_d_bits_opcode  = '0;
    m1_d_bits_param   = '0;
    m1_d_bits_size    = '0;
    m1_d_bits_source  = 1'b0;
    m1_d_bits_sink    = 1'b0;
    m1_d_bits_addr_lo = '0;
    m1_d_bits_data    = '0;
    m1_d_bits_error   = 1'b0;
    case (state)
      REQ: begin
        if (owner) begin
          s_a_valid        = m1_a_valid;
          s_a_bits_opcode  = m1_a_bits_opcode;
          s_a_bits_param   = m1_a_bits_param;
          s_a_bits_size    = m1_a_bits_size;
          s_a_bits_source  = m1_a_bits_source;
          s_a_bits_address = m1_a_bits_address;
          s_a_bits_mask    = m1_a_bits_mask;
          s_a_bits_data    = m1_a_bits_data;
          m1_a_ready       = s_a_ready;
        end else begin
          s_a_valid        = m0_a_valid;
          s_a_bits_opcode  = m0_a_bits_opcode;
          s_a_bits_param   = m0_a_bits_param;
          s_a_bits_size    = m0_a_bits_size;
          s_a_bits_source  = m0_a_bits_source;
          s_a_bits_address = m0_a_bits_address;
          s_a_bits_mask    = m0_a_bits_mask;
          s_a_bits_data    = m0_a_bits_data;
          m0_a_ready       = s_a_ready;
        end
      end
      RESP: begin
        if (owner) begin
          m1_d_valid        = s_d_valid;
          m1_d_bits_opcode  = s_d_bits_opcode;
          m1_d_bits_param   = s_d_bits_param;
          m1_d_bits_size    = s_d_bits_size;
          m1_d_bits_source  = s_d_bits_source;
          m1_d_bits_sink    = s_d_bits_sink;
          m1_d_bits_addr_lo = s_d_bits_addr_lo;
          m1_d_bits_data    = s_d_bits_data;
          m1_d_bits_error   = s_d_bits_error;
          s_d_ready         = m1_d_ready;
        end else begin
          m0_d_valid        = s_d_valid;
          m0_d_bits_opcode  = s_d_bits_opcode;
          m0_d_bits_param   = s_d_bits_param;
          m0_d_bits_size    = s_d_bits_size;
          m0_d_bits_source  = s_d_bits_source;
          m0_d_bits_sink    = s_d_bits_sink;
          m0_d_bits_addr_lo = s_d_bits_addr_lo;
          m0_d_bits_data    = s_d_bits_data;
          m0_d_bits_error   = s_d_bits_error;
          s_d_ready         = m0_d_ready;
        end
      end
      default: ;
    endcase
  end

endmodule
